// File: rtl/ir_pkg.sv
// Shared constants and helpers for the instruction-register prefetch queue.
package ir_pkg;

  // Default geometry: 8-bit instruction words, 4-entry prefetch, 4-bit opcode.
  localparam int DEFAULT_WIDTH = 8;
  localparam int DEFAULT_DEPTH = 4;
  localparam int DEFAULT_OPC_W = 4;

  // Number of bits needed to hold values 0 .. value-1 (minimum 1).
  // Used with DEPTH+1 for the occupancy counter and DEPTH for pointers.
  function automatic int clog2(input int value);
    int bits;
    bits = 1;
    while ((1 << bits) < value) begin
      bits = bits + 1;
    end
    return bits;
  endfunction

endpackage

// File: rtl/ir_sync_fifo.sv
// Synchronous prefetch FIFO: storage array, wrapping head/tail pointers,
// occupancy count and full/empty flags. Flush clears pointers and count in
// one cycle and wins over any push or pop in that cycle.
module ir_sync_fifo
  import ir_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int DEPTH = DEFAULT_DEPTH,
  localparam int CNT_W = clog2(DEPTH + 1),
  localparam int PTR_W = clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] data_in,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] head_ptr;
  logic [PTR_W-1:0] tail_ptr;
  logic             wr_en;
  logic             rd_en;

  // Requests are qualified here so the caller can pass raw strobes:
  // a push into a full FIFO or a pop from an empty one is ignored.
  always_comb begin
    full  = (count == CNT_W'(DEPTH));
    empty = (count == '0);
    wr_en = push && !full && !flush;
    rd_en = pop && !empty && !flush;
  end

  // The head word is always presented, so a pop can load it the same edge.
  assign head_data = mem[head_ptr];

  // Storage array: no reset needed, validity is tracked by the count.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[tail_ptr] <= data_in;
    end
  end

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      head_ptr <= '0;
      tail_ptr <= '0;
    end else begin
      if (wr_en) begin
        tail_ptr <= tail_ptr + PTR_W'(1);
      end
      if (rd_en) begin
        head_ptr <= head_ptr + PTR_W'(1);
      end
    end
  end

  // Occupancy: count + push - pop, bounded by the qualification above.
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      count <= '0;
    end else begin
      case ({wr_en, rd_en})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ir_prefetch_queue.sv
// Instruction register with a prefetch FIFO in front of it. Memory pushes
// words ahead of decode; HIR loads the head word into the IR, which is also
// presented split into opcode and operand fields.
//
// Handshake: a word on DATA_IN is accepted at a rising edge when DATA_VALID
// and FETCH_RDY are both high. FETCH_RDY depends only on the registered
// occupancy (never on HIR), so a full queue refuses a push even when the
// same edge pops. A DATA_VALID seen while FETCH_RDY is low drops the word and
// sets the sticky OVF flag. FLUSH overrides everything except reset.
module ir_prefetch_queue
  import ir_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int OPC_W = DEFAULT_OPC_W,
  localparam int CNT_W = clog2(DEPTH + 1)
) (
  input  logic                   CLK,
  input  logic                   RESET_N,
  input  logic [WIDTH-1:0]       DATA_IN,
  input  logic                   DATA_VALID,
  output logic                   FETCH_RDY,
  input  logic                   HIR,
  input  logic                   FLUSH,
  output logic [WIDTH-1:0]       IR_OUT,
  output logic                   IR_VALID,
  output logic [OPC_W-1:0]       IR_OPCODE,
  output logic [WIDTH-OPC_W-1:0] IR_OPERAND,
  output logic [CNT_W-1:0]       COUNT,
  output logic                   OVF
);

  logic [WIDTH-1:0] head_data;
  logic             fifo_full;
  logic             fifo_empty;

  ir_sync_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (CLK),
    .rst_n     (RESET_N),
    .flush     (FLUSH),
    .push      (DATA_VALID),
    .data_in   (DATA_IN),
    .pop       (HIR),
    .head_data (head_data),
    .count     (COUNT),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign FETCH_RDY = !fifo_full;

  // Instruction register: load on HIR when a word is queued; an HIR with an
  // empty queue keeps the old word but marks it stale. No bypass from DATA_IN.
  always_ff @(posedge CLK) begin
    if (!RESET_N || FLUSH) begin
      IR_OUT   <= '0;
      IR_VALID <= 1'b0;
    end else if (HIR) begin
      if (!fifo_empty) begin
        IR_OUT   <= head_data;
        IR_VALID <= 1'b1;
      end else begin
        IR_VALID <= 1'b0;
      end
    end
  end

  // Sticky overflow: a push attempt while full; a flushed push does not count.
  always_ff @(posedge CLK) begin
    if (!RESET_N || FLUSH) begin
      OVF <= 1'b0;
    end else if (DATA_VALID && fifo_full) begin
      OVF <= 1'b1;
    end
  end

  // Field split of the current instruction: opcode in the MSBs.
  assign IR_OPCODE  = IR_OUT[WIDTH-1 -: OPC_W];
  assign IR_OPERAND = IR_OUT[WIDTH-OPC_W-1:0];

endmodule

// File: tb/tb_ir_prefetch_queue.sv
// Bench for ir_prefetch_queue: directed scenarios with literal expectations
// followed by a randomized phase, all checked every cycle against a
// queue-based model of the prefetch queue and instruction register.
module tb_ir_prefetch_queue;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
  localparam int OPC_W = 4;

  // ---------------- clock / reset ----------------
  logic       clk;
  logic       rst_n;
  logic [7:0] data_in;
  logic       data_valid;
  logic       hir;
  logic       flush;
  logic       fetch_rdy;
  logic [7:0] ir_out;
  logic       ir_valid;
  logic [3:0] ir_opcode;
  logic [3:0] ir_operand;
  logic [2:0] count;
  logic       ovf;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  ir_prefetch_queue #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .OPC_W (OPC_W)
  ) dut (
    .CLK        (clk),
    .RESET_N    (rst_n),
    .DATA_IN    (data_in),
    .DATA_VALID (data_valid),
    .FETCH_RDY  (fetch_rdy),
    .HIR        (hir),
    .FLUSH      (flush),
    .IR_OUT     (ir_out),
    .IR_VALID   (ir_valid),
    .IR_OPCODE  (ir_opcode),
    .IR_OPERAND (ir_operand),
    .COUNT      (count),
    .OVF        (ovf)
  );

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad   = 0;

  logic [WIDTH-1:0] exp_q[$];
  logic [WIDTH-1:0] exp_ir  = '0;
  logic             exp_irv = 1'b0;
  logic             exp_ovf = 1'b0;
  bit               model_live = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a queue of words plus the IR, advanced on every edge.
  always @(posedge clk) begin
    if (!rst_n || flush) begin
      exp_q.delete();
      exp_ir     = '0;
      exp_irv    = 1'b0;
      exp_ovf    = 1'b0;
      if (!rst_n) model_live = 1'b1;
    end else begin
      bit was_full;
      was_full = (exp_q.size() == DEPTH);
      if (hir) begin
        if (exp_q.size() != 0) begin
          exp_ir  = exp_q.pop_front();
          exp_irv = 1'b1;
        end else begin
          exp_irv = 1'b0;
        end
      end
      if (data_valid) begin
        if (!was_full) exp_q.push_back(data_in);
        else           exp_ovf = 1'b1;
      end
    end
  end

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    if (model_live) begin
      check("ir_out",     32'(ir_out),     32'(exp_ir));
      check("ir_valid",   32'(ir_valid),   32'(exp_irv));
      check("ir_opcode",  32'(ir_opcode),  32'(exp_ir / 16));
      check("ir_operand", 32'(ir_operand), 32'(exp_ir % 16));
      check("count",      32'(count),      32'(exp_q.size()));
      check("fetch_rdy",  32'(fetch_rdy),  32'(exp_q.size() < DEPTH));
      check("ovf",        32'(ovf),        32'(exp_ovf));
    end
  end

  // ---------------- driver ----------------
  task automatic drive(input logic dv, input logic [7:0] d, input logic h, input logic f);
    data_valid = dv;
    data_in    = d;
    hir        = h;
    flush      = f;
    @(posedge clk);
    #1;
    data_valid = 1'b0;
    hir        = 1'b0;
    flush      = 1'b0;
  endtask

  task automatic push(input logic [7:0] d);
    drive(1'b1, d, 1'b0, 1'b0);
  endtask

  task automatic pop_expect(input logic [7:0] d);
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    check("pop_ir_out", 32'(ir_out), 32'(d));
    check("pop_ir_valid", 32'(ir_valid), 32'd1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n      = 1'b0;
    data_in    = 8'hFF;
    data_valid = 1'b1;
    hir        = 1'b1;
    flush      = 1'b0;

    // 1. reset with push/pop requests held high
    repeat (2) @(posedge clk);
    #1;
    rst_n      = 1'b1;
    data_valid = 1'b0;
    hir        = 1'b0;
    check("rst_ir_out", 32'(ir_out), 32'h00);
    check("rst_ir_valid", 32'(ir_valid), 32'd0);
    check("rst_count", 32'(count), 32'd0);
    check("rst_fetch_rdy", 32'(fetch_rdy), 32'd1);
    check("rst_ovf", 32'(ovf), 32'd0);

    // 2. two pushes then two pops, with field split
    push(8'hA5);
    push(8'h3C);
    check("t2_count2", 32'(count), 32'd2);
    pop_expect(8'hA5);
    check("t2_opc_a", 32'(ir_opcode), 32'hA);
    check("t2_opr_5", 32'(ir_operand), 32'h5);
    check("t2_count1", 32'(count), 32'd1);
    pop_expect(8'h3C);
    check("t2_opc_3", 32'(ir_opcode), 32'h3);
    check("t2_opr_c", 32'(ir_operand), 32'hC);
    check("t2_count0", 32'(count), 32'd0);

    // 3. fill, overflow, drain, and refill across the wrap
    for (int i = 0; i < 4; i++) push(8'h10 + 8'(i));
    check("t3_full_rdy", 32'(fetch_rdy), 32'd0);
    check("t3_full_count", 32'(count), 32'd4);
    push(8'h14);
    check("t3_ovf", 32'(ovf), 32'd1);
    check("t3_count_after_drop", 32'(count), 32'd4);
    for (int i = 0; i < 4; i++) pop_expect(8'h10 + 8'(i));
    for (int i = 0; i < 4; i++) push(8'h20 + 8'(i));
    // full: a pop in the same cycle must not admit the push
    drive(1'b1, 8'h2F, 1'b1, 1'b0);
    check("t3_full_pop_push_count", 32'(count), 32'd3);
    check("t3_full_pop_ir", 32'(ir_out), 32'h20);
    for (int i = 1; i < 4; i++) pop_expect(8'h20 + 8'(i));
    check("t3_ovf_sticky", 32'(ovf), 32'd1);

    // 4. simultaneous push and pop with two words queued
    push(8'h40);
    push(8'h41);
    drive(1'b1, 8'h77, 1'b1, 1'b0);
    check("t4_count", 32'(count), 32'd2);
    check("t4_ir", 32'(ir_out), 32'h40);
    pop_expect(8'h41);
    pop_expect(8'h77);

    // 5. pop from empty with a same-cycle push: no bypass
    drive(1'b1, 8'h55, 1'b1, 1'b0);
    check("t5_ir_valid", 32'(ir_valid), 32'd0);
    check("t5_ir_hold", 32'(ir_out), 32'h77);
    check("t5_count", 32'(count), 32'd1);
    pop_expect(8'h55);

    // 6. flush beats push and pop
    push(8'h61);
    push(8'h62);
    push(8'h63);
    check("t6_count3", 32'(count), 32'd3);
    drive(1'b1, 8'h99, 1'b1, 1'b1);
    check("t6_count", 32'(count), 32'd0);
    check("t6_ir", 32'(ir_out), 32'h00);
    check("t6_ir_valid", 32'(ir_valid), 32'd0);
    check("t6_ovf", 32'(ovf), 32'd0);
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    check("t6_no_99", 32'(ir_valid), 32'd0);

    // randomized phase: biased segments sweep empty, mid and full occupancy
    for (int seg = 0; seg < 8; seg++) begin
      int push_pct;
      int pop_pct;
      push_pct = $urandom_range(20, 90);
      pop_pct  = $urandom_range(20, 90);
      for (int n = 0; n < 250; n++) begin
        rst_n = ($urandom_range(0, 199) != 0);
        drive(($urandom_range(0, 99) < push_pct), 8'($urandom),
              ($urandom_range(0, 99) < pop_pct), ($urandom_range(0, 59) == 0));
        rst_n = 1'b1;
      end
    end

    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
